pipe_scoreboard: RTL and testbench

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

---
 rtl/sb_pkg.sv | 19 +
 rtl/ctrl_bus_if.sv | 8 +
 rtl/sb_match.sv | 50 +++++
 rtl/pipe_scoreboard.sv | 140 ++++++++++++++
 tb/tb_pipe_scoreboard.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared types for the pipeline scoreboard.
// sb_entry_t is sized for register ids of up to ID_W_MAX bits.
// Narrower ids are zero-extended into the dst field.
package sb_pkg;

  localparam int unsigned ALU_LAT  = 1;
  localparam int unsigned ID_W_MAX = 8;
  localparam int unsigned LAT_W    = 3;

  // Stage index of a forwarding source; 0 means the register file.
  typedef logic [2:0] fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] dst;
    logic [LAT_W-1:0]    lat;
  } sb_entry_t;

endpackage

// File: rtl/ctrl_bus_if.sv
// ctrl_bus_if: the single clock and the asynchronous active-low reset shared by the control block.
interface ctrl_bus_if;
  logic clk;
  logic rst_n;

  modport central (input clk, input rst_n);
  modport source  (output clk, output rst_n);
endinterface

// File: rtl/sb_match.sv
// sb_match: combinational youngest-producer finder for one source operand.
// Returns whether a producer matches, its stage k, and whether its value can
// be consumed now (D-consumer, br=1) or next cycle in E (br=0).
// FWD_EN is set by the top from the SB_FORWARD_EN macro.
module sb_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned REG_W  = 5,
  parameter bit          FWD_EN = 1'b0
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [REG_W-1:0]      src,
  input  logic                  use_src,
  input  logic                  br,
  output logic                  hit,
  output fwd_sel_t              k,
  output logic                  ready
);

  int unsigned hit_k;
  int unsigned hit_lat;

  // Scan from the youngest stage; the first match shadows older writers of the same id.
  always_comb begin
    hit     = 1'b0;
    hit_k   = 0;
    hit_lat = 0;
    ready   = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit && use_src && (src != '0) && entries[i].valid &&
          (entries[i].dst == ID_W_MAX'(src))) begin
        hit     = 1'b1;
        hit_k   = i;
        hit_lat = 32'(entries[i].lat);
      end
    end
    k = fwd_sel_t'(hit_k);
    if (hit) begin
      if (FWD_EN) begin
        // W is not a bypass source for D reads: the register file sees it a cycle later.
        if (br) ready = (hit_k >= hit_lat) && (hit_k != DEPTH - 1);
        else    ready = (hit_k + 1 >= hit_lat);
      end else begin
        ready = (hit_k == DEPTH - 1);
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: register-dependency scoreboard for the post-decode stages.
// Tracks in-flight producers, drives stall/flush steering and operand
// forwarding selects. Forwarding exists only when SB_FORWARD_EN is defined;
// otherwise fwd outputs are 0 and consumers wait until the producer is in W.
module pipe_scoreboard
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 2
) (
  ctrl_bus_if.central                  ctrl_bus,
  input  logic [REG_W-1:0]             rs_D,
  input  logic [REG_W-1:0]             rt_D,
  input  logic                         use_rs_D,
  input  logic                         use_rt_D,
  input  logic                         br_D,
  input  logic [REG_W-1:0]             dst_D,
  input  logic                         reg_write_D,
  input  logic                         load_D,
  input  logic                         redirect_D,
  output logic                         pc_enab,
  output logic                         enab_FD,
  output logic                         flush_FD,
  output logic                         flush_DE,
  output logic [$clog2(DEPTH)-1:0]     fwdA_D,
  output logic [$clog2(DEPTH)-1:0]     fwdB_D,
  output logic [$clog2(DEPTH)-1:0]     fwdA_E,
  output logic [$clog2(DEPTH)-1:0]     fwdB_E,
  output logic [31:0]                  stall_cnt
);

`ifdef SB_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam int unsigned FW = $clog2(DEPTH);

  logic clk;
  logic rst_n;
  assign clk   = ctrl_bus.clk;
  assign rst_n = ctrl_bus.rst_n;

  sb_entry_t [DEPTH-1:0] entry_q;
  sb_entry_t             new_entry;

  logic     hit_a, hit_b;
  logic     ready_a, ready_b;
  fwd_sel_t k_a, k_b;
  logic     stall;

  // Stage the operand will occupy when the consumer reaches E; a producer leaving W is read from the register file.
  function automatic fwd_sel_t next_stage(input fwd_sel_t k);
    int unsigned kn;
    kn = 32'(k) + 1;
    return (kn <= DEPTH - 1) ? fwd_sel_t'(kn) : '0;
  endfunction

  sb_match #(.DEPTH(DEPTH), .REG_W(REG_W), .FWD_EN(FWD_EN)) u_match_a (
    .entries (entry_q),
    .src     (rs_D),
    .use_src (use_rs_D),
    .br      (br_D),
    .hit     (hit_a),
    .k       (k_a),
    .ready   (ready_a)
  );

  sb_match #(.DEPTH(DEPTH), .REG_W(REG_W), .FWD_EN(FWD_EN)) u_match_b (
    .entries (entry_q),
    .src     (rt_D),
    .use_src (use_rt_D),
    .br      (br_D),
    .hit     (hit_b),
    .k       (k_b),
    .ready   (ready_b)
  );

  // Hazard decision and pipeline steering.
  always_comb begin
    stall    = (hit_a && !ready_a) || (hit_b && !ready_b);
    pc_enab  = !stall;
    enab_FD  = !stall;
    flush_DE = stall;
    flush_FD = redirect_D && !stall;
  end

  // Descriptor entering E; a stalled decode injects a bubble.
  always_comb begin
    new_entry       = '0;
    new_entry.valid = reg_write_D && (dst_D != '0) && !stall;
    new_entry.dst   = ID_W_MAX'(dst_D);
    new_entry.lat   = load_D ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
  end

  // Decode-stage forwarding selects for operands consumed in D.
  always_comb begin
    fwdA_D = '0;
    fwdB_D = '0;
    if (FWD_EN && br_D) begin
      if (hit_a && ready_a) fwdA_D = FW'(k_a);
      if (hit_b && ready_b) fwdB_D = FW'(k_b);
    end
  end

  // Entries advance one stage every clock regardless of stall; the oldest retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= {entry_q[DEPTH-2:0], new_entry};
    end
  end

  // E-stage forwarding selects, captured as the decode instruction moves into E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwdA_E <= '0;
      fwdB_E <= '0;
    end else if (stall || !FWD_EN) begin
      fwdA_E <= '0;
      fwdB_E <= '0;
    end else begin
      fwdA_E <= hit_a ? FW'(next_stage(k_a)) : '0;
      fwdB_E <= hit_b ? FW'(next_stage(k_b)) : '0;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed hazard scenarios plus randomized traffic,
// checked every cycle against a behavioural model of in-flight producers.
// Expectations follow SB_FORWARD_EN the same way the design does.
module tb_pipe_scoreboard;

  localparam int DEPTH    = 3;
  localparam int REG_W    = 5;
  localparam int LOAD_LAT = 2;

`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  ctrl_bus_if bus ();

  logic [REG_W-1:0] rs_D, rt_D, dst_D;
  logic use_rs_D, use_rt_D, br_D, reg_write_D, load_D, redirect_D;
  logic pc_enab, enab_FD, flush_FD, flush_DE;
  logic [1:0] fwdA_D, fwdB_D, fwdA_E, fwdB_E;
  logic [31:0] stall_cnt;

  pipe_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W), .LOAD_LAT(LOAD_LAT)) dut (
    .ctrl_bus    (bus),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .use_rs_D    (use_rs_D),
    .use_rt_D    (use_rt_D),
    .br_D        (br_D),
    .dst_D       (dst_D),
    .reg_write_D (reg_write_D),
    .load_D      (load_D),
    .redirect_D  (redirect_D),
    .pc_enab     (pc_enab),
    .enab_FD     (enab_FD),
    .flush_FD    (flush_FD),
    .flush_DE    (flush_DE),
    .fwdA_D      (fwdA_D),
    .fwdB_D      (fwdB_D),
    .fwdA_E      (fwdA_E),
    .fwdB_E      (fwdB_E),
    .stall_cnt   (stall_cnt)
  );

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  int checks = 0;
  int errors = 0;

  // Model: producers in flight indexed by age (cycles since entering E).
  bit     m_v   [DEPTH];
  int     m_dst [DEPTH];
  int     m_lat [DEPTH];
  int     m_fwdA_E, m_fwdB_E;
  longint m_cnt;
  bit     last_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      m_v[a] = 1'b0; m_dst[a] = 0; m_lat[a] = 0;
    end
    m_fwdA_E = 0; m_fwdB_E = 0; m_cnt = 0; last_stall = 1'b0;
  endtask

  // A value is readable in D once its age reaches its latency (W excluded: regfile
  // holds it a cycle later); an E read happens one cycle later than the D read.
  function automatic void eval_src(input int id, input bit use_it, input bit br,
                                   output bit hit, output bit ok, output int age);
    hit = 1'b0; ok = 1'b1; age = 0;
    if (!use_it || id == 0) return;
    for (int a = 0; a < DEPTH; a++) begin
      if (m_v[a] && m_dst[a] == id) begin
        hit = 1'b1; age = a; break;
      end
    end
    if (!hit) return;
    if (!FWD)    ok = (age == DEPTH - 1);
    else if (br) ok = (age >= m_lat[age]) && (age != DEPTH - 1);
    else         ok = (age + 1 >= m_lat[age]);
  endfunction

  task automatic drive_idle();
    rs_D = '0; rt_D = '0; use_rs_D = 0; use_rt_D = 0; br_D = 0;
    dst_D = '0; reg_write_D = 0; load_D = 0; redirect_D = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    redirect_D = 1'b1;
    bus.rst_n  = 1'b0;
    #1;
    chk("rst_pc_enab", pc_enab, 1);
    chk("rst_enab_FD", enab_FD, 1);
    chk("rst_flush_FD", flush_FD, 1);
    chk("rst_flush_DE", flush_DE, 0);
    chk("rst_fwdA_D", fwdA_D, 0);
    chk("rst_fwdB_D", fwdB_D, 0);
    chk("rst_fwdA_E", fwdA_E, 0);
    chk("rst_fwdB_E", fwdB_E, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    model_clear();
    repeat (2) @(posedge bus.clk);
    @(negedge bus.clk);
    redirect_D = 1'b0;
    bus.rst_n  = 1'b1;
  endtask

  // One decode cycle: drive after the edge, check mid-cycle, advance the model past the next edge.
  task automatic cycle(input int rs, input int rt, input bit urs, input bit urt, input bit br,
                       input int dst, input bit rw, input bit ld, input bit rd);
    bit ha, hb, oka, okb, st;
    int aa, ab;
    @(posedge bus.clk);
    #1;
    rs_D = REG_W'(rs); rt_D = REG_W'(rt); use_rs_D = urs; use_rt_D = urt; br_D = br;
    dst_D = REG_W'(dst); reg_write_D = rw; load_D = ld; redirect_D = rd;
    @(negedge bus.clk);
    eval_src(rs, urs, br, ha, oka, aa);
    eval_src(rt, urt, br, hb, okb, ab);
    st = (ha && !oka) || (hb && !okb);
    chk("pc_enab", pc_enab, !st);
    chk("enab_FD", enab_FD, !st);
    chk("flush_DE", flush_DE, st);
    chk("flush_FD", flush_FD, rd && !st);
    chk("fwdA_D", fwdA_D, (FWD && br && ha && oka) ? aa : 0);
    chk("fwdB_D", fwdB_D, (FWD && br && hb && okb) ? ab : 0);
    chk("fwdA_E", fwdA_E, m_fwdA_E);
    chk("fwdB_E", fwdB_E, m_fwdB_E);
    chk("stall_cnt", stall_cnt, m_cnt);
    last_stall = st;
    for (int a = DEPTH - 1; a > 0; a--) begin
      m_v[a] = m_v[a-1]; m_dst[a] = m_dst[a-1]; m_lat[a] = m_lat[a-1];
    end
    m_v[0]   = !st && rw && (dst != 0);
    m_dst[0] = dst;
    m_lat[0] = ld ? LOAD_LAT : 1;
    m_fwdA_E = (!st && FWD && ha) ? ((aa + 1 <= DEPTH - 1) ? aa + 1 : 0) : 0;
    m_fwdB_E = (!st && FWD && hb) ? ((ab + 1 <= DEPTH - 1) ? ab + 1 : 0) : 0;
    if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Re-present a consumer until it is accepted; returns the number of stalled cycles.
  task automatic consume(input int rs, input int rt, input bit urs, input bit urt, input bit br,
                         input int dst, input bit rw, input bit rd, output int stalls);
    stalls = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(rs, rt, urs, urt, br, dst, rw, 0, rd);
      if (!last_stall) break;
      stalls++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls;
    drive_idle();

    // ALU back-to-back: add r3 ; sub r4,r3
    do_reset();
    cycle(0, 0, 0, 0, 0, 3, 1, 0, 0);
    consume(3, 0, 1, 0, 0, 4, 1, 0, stalls);
    chk("alu_b2b_stalls", stalls, FWD ? 0 : 2);
    nop();
    chk("alu_b2b_fwdA_E", fwdA_E, FWD ? 1 : 0);

    // Load-use: lw r5 ; add r6,r5
    do_reset();
    cycle(0, 0, 0, 0, 0, 5, 1, 1, 0);
    cycle(5, 0, 1, 0, 0, 6, 1, 0, 0);
    chk("load_use_flush_DE", flush_DE, 1);
    consume(5, 0, 1, 0, 0, 6, 1, 0, stalls);
    chk("load_use_stalls", stalls + 1, FWD ? 1 : 2);
    nop();
    chk("load_use_fwdA_E", fwdA_E, FWD ? 2 : 0);
    chk("load_use_stall_cnt", stall_cnt, FWD ? 1 : 2);

    // Branch after ALU: add r7 ; beq r7
    do_reset();
    cycle(0, 0, 0, 0, 0, 7, 1, 0, 0);
    consume(7, 0, 1, 0, 1, 0, 0, 0, stalls);
    chk("br_alu_stalls", stalls, FWD ? 1 : 2);
    chk("br_alu_fwdA_D", fwdA_D, FWD ? 1 : 0);

    // Redirect coincident with a stall is dropped until the branch is accepted
    do_reset();
    cycle(0, 0, 0, 0, 0, 7, 1, 0, 0);
    cycle(7, 0, 1, 0, 1, 0, 0, 0, 1);
    chk("redir_stalled_flush_FD", flush_FD, 0);
    consume(7, 0, 1, 0, 1, 0, 0, 1, stalls);
    chk("redir_accept_flush_FD", flush_FD, 1);

    // Writes to r0 never create a hazard
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    consume(0, 0, 1, 1, 0, 1, 1, 0, stalls);
    chk("r0_stalls", stalls, 0);
    nop();
    chk("r0_fwdA_E", fwdA_E, 0);

    // Reset asserted in the middle of a load-use stall
    do_reset();
    cycle(0, 0, 0, 0, 0, 5, 1, 1, 0);
    cycle(5, 0, 1, 0, 0, 6, 1, 0, 0);
    chk("midstall_pc_enab_before", pc_enab, 0);
    #2;
    bus.rst_n = 1'b0;
    #1;
    chk("midstall_pc_enab_reset", pc_enab, 1);
    chk("midstall_stall_cnt_reset", stall_cnt, 0);
    model_clear();
    do_reset();

    // Randomized traffic over a small register set to provoke frequent hazards
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
